// File: rtl/ed_channel_scheduler.sv
// Round-robin scheduler sharing one energy-detection core between NUM_CH sample FIFOs,
// with a per-window watchdog that recovers the core when end-of-window never arrives.
module ed_channel_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_empty,
  output logic [NUM_CH-1:0] ch_pop,
  output logic              core_empty,
  input  logic              core_pop,
  output logic              core_sclr,
  input  logic              core_end,
  input  logic              core_dres,
  output logic              dec_valid,
  output logic [CH_W-1:0]   dec_ch,
  output logic              dec_result,
  output logic [NUM_CH-1:0] dec_vector,
  output logic              timeout_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_CLEAR,
    S_RUN,
    S_COLLECT,
    S_ABORT
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [TO_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic [CH_W-1:0]     dec_ch_q, dec_ch_d;
  logic                dec_result_q, dec_result_d;
  logic [NUM_CH-1:0]   dec_vector_q, dec_vector_d;

  // Round-robin search split in two passes: channels at/after rr_ptr, then the wrapped ones.
  // Iterating downward lets the lowest matching index win without a priority chain.
  logic            hi_found, lo_found, sel_found;
  logic [CH_W-1:0] hi_idx, lo_idx, sel_idx;
  logic [CH_W-1:0] grant_next;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!ch_empty[i]) begin
        lo_found = 1'b1;
        lo_idx   = CH_W'(i);
        if (CH_W'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = CH_W'(i);
        end
      end
    end
    sel_found = hi_found | lo_found;
    sel_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Explicit wrap so non-power-of-two channel counts stay in range.
  assign grant_next = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    wd_cnt_d     = wd_cnt_q;
    dec_ch_d     = dec_ch_q;
    dec_result_d = dec_result_q;
    dec_vector_d = dec_vector_q;
    core_empty   = 1'b1;
    ch_pop       = '0;
    core_sclr    = 1'b0;
    dec_valid    = 1'b0;
    timeout_err  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable && (~ch_empty != '0)) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (sel_found) begin
          grant_d = sel_idx;
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        core_sclr = 1'b1;
        wd_cnt_d  = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        core_empty      = ch_empty[grant_q];
        ch_pop[grant_q] = core_pop & ~ch_empty[grant_q];
        wd_cnt_d        = wd_cnt_q + 1'b1;
        if (core_end) begin
          // Decision is captured in the end cycle so it is presented with dec_valid.
          state_d               = S_COLLECT;
          dec_ch_d              = grant_q;
          dec_result_d          = core_dres;
          dec_vector_d[grant_q] = core_dres;
        end else if (wd_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d = S_ABORT;
        end
      end
      S_COLLECT: begin
        dec_valid = 1'b1;
        rr_ptr_d  = grant_next;
        state_d   = S_IDLE;
      end
      S_ABORT: begin
        timeout_err = 1'b1;
        core_sclr   = 1'b1;
        rr_ptr_d    = grant_next;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      wd_cnt_q     <= '0;
      dec_ch_q     <= '0;
      dec_result_q <= 1'b0;
      dec_vector_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      wd_cnt_q     <= wd_cnt_d;
      dec_ch_q     <= dec_ch_d;
      dec_result_q <= dec_result_d;
      dec_vector_q <= dec_vector_d;
    end
  end

  assign dec_ch     = dec_ch_q;
  assign dec_result = dec_result_q;
  assign dec_vector = dec_vector_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ed_channel_scheduler.sv
// Scoreboard bench for ed_channel_scheduler: stimulus pushes expected decisions/aborts,
// a negedge monitor pops and compares whenever dec_valid or timeout_err appears.
module tb_ed_channel_scheduler;

  localparam int NUM_CH  = 4;
  localparam int CH_W    = 2;
  localparam int TIMEOUT = 1024;
  localparam int TO_W    = 11;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic [NUM_CH-1:0] ch_empty;
  logic [NUM_CH-1:0] ch_pop;
  logic              core_empty;
  logic              core_pop;
  logic              core_sclr;
  logic              core_end;
  logic              core_dres;
  logic              dec_valid;
  logic [CH_W-1:0]   dec_ch;
  logic              dec_result;
  logic [NUM_CH-1:0] dec_vector;
  logic              timeout_err;
  logic              busy;

  typedef struct {
    bit                is_to;
    int                ch;
    logic              res;
    logic [NUM_CH-1:0] vec;
  } exp_t;

  exp_t              sb[$];
  logic [NUM_CH-1:0] exp_vec;
  int                n_checks = 0;
  int                n_errors = 0;

  ed_channel_scheduler #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .ch_empty   (ch_empty),
    .ch_pop     (ch_pop),
    .core_empty (core_empty),
    .core_pop   (core_pop),
    .core_sclr  (core_sclr),
    .core_end   (core_end),
    .core_dres  (core_dres),
    .dec_valid  (dec_valid),
    .dec_ch     (dec_ch),
    .dec_result (dec_result),
    .dec_vector (dec_vector),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every decision / abort pulse against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && (dec_valid || timeout_err)) begin
        if (sb.size() == 0) begin
          check("unexpected_output_pulse", {30'd0, dec_valid, timeout_err}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("pulse_kind_timeout", {31'd0, timeout_err}, {31'd0, e.is_to});
          check("pulse_kind_valid", {31'd0, dec_valid}, {31'd0, !e.is_to});
          check("dec_vector", {28'd0, dec_vector}, {28'd0, e.vec});
          if (e.is_to) begin
            check("abort_sclr", {31'd0, core_sclr}, 32'd1);
          end else begin
            check("dec_ch", {30'd0, dec_ch}, e.ch);
            check("dec_result", {31'd0, dec_result}, {31'd0, e.res});
          end
        end
      end
    end
  end

  task automatic wait_sclr(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = core_sclr;
    end
    check("sclr_seen", {31'd0, seen}, 32'd1);
  endtask

  // One detection window: core_end raised in RUN cycle end_cycle, or never when expect_to.
  // Returns at the negedge of the COLLECT/ABORT cycle.
  task automatic run_window(input int exp_ch, input logic dres, input int end_cycle,
                            input bit expect_to);
    bit   seen;
    exp_t e;
    wait_sclr(seen);
    if (!seen) return;
    core_pop = 1'b1;
    @(negedge clock);
    check("sclr_one_cycle", {31'd0, core_sclr}, 32'd0);
    check("ch_pop_grant", {28'd0, ch_pop}, 32'd1 << exp_ch);
    check("core_empty_run", {31'd0, core_empty}, 32'd0);
    if (expect_to) begin
      for (int c = 2; c <= TIMEOUT; c++) @(negedge clock);
      check("no_early_timeout", {31'd0, timeout_err}, 32'd0);
      e.is_to = 1'b1; e.ch = exp_ch; e.res = 1'b0; e.vec = exp_vec;
      sb.push_back(e);
      core_pop = 1'b0;
      @(negedge clock);
    end else begin
      for (int c = 2; c <= end_cycle; c++) @(negedge clock);
      core_end  = 1'b1;
      core_dres = dres;
      exp_vec[exp_ch] = dres;
      e.is_to = 1'b0; e.ch = exp_ch; e.res = dres; e.vec = exp_vec;
      sb.push_back(e);
      @(negedge clock);
      core_end  = 1'b0;
      core_dres = 1'b0;
      core_pop  = 1'b0;
    end
  endtask

  task automatic do_reset();
    check("scoreboard_drained", sb.size(), 32'd0);
    reset    = 1'b1;
    core_pop = 1'b0;
    core_end = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset   = 1'b0;
    exp_vec = '0;
  endtask

  initial begin
    logic dres_pat [5];
    bit   seen;
    dres_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    reset     = 1'b1;
    enable    = 1'b1;
    ch_empty  = 4'b1111;
    core_pop  = 1'b0;
    core_end  = 1'b0;
    core_dres = 1'b0;
    exp_vec   = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Test 1: nothing to schedule, then data present but enable low.
    repeat (5) @(negedge clock);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_core_empty", {31'd0, core_empty}, 32'd1);
    check("idle_ch_pop", {28'd0, ch_pop}, 32'd0);
    check("idle_sclr", {31'd0, core_sclr}, 32'd0);
    enable   = 1'b0;
    ch_empty = 4'b1011;
    repeat (5) @(negedge clock);
    check("disabled_busy", {31'd0, busy}, 32'd0);

    // Test 2: only ch2 ready, decision 1 after 40 RUN cycles.
    enable = 1'b1;
    run_window(2, 1'b1, 40, 1'b0);
    check("t2_dec_vector", {28'd0, dec_vector}, 32'h4);
    @(negedge clock);
    check("t2_dec_ch_hold", {30'd0, dec_ch}, 32'd2);
    check("t2_dec_result_hold", {31'd0, dec_result}, 32'd1);

    // Test 3: all channels ready, five windows rotate 0,1,2,3,0.
    ch_empty = 4'b1111;
    do_reset();
    ch_empty = 4'b0000;
    for (int k = 0; k < 5; k++) run_window(k % 4, dres_pat[k], 5 + k, 1'b0);
    check("t3_dec_vector", {28'd0, dec_vector}, 32'hC);

    // Test 4: ch3 window with no core_end aborts at RUN cycle 1024.
    ch_empty = 4'b0111;
    run_window(3, 1'b0, 0, 1'b1);
    check("t4_vector_unchanged", {28'd0, dec_vector}, 32'hC);

    // Test 5: next grant is ch0; core_end exactly on the last watchdog cycle.
    ch_empty = 4'b0000;
    run_window(0, 1'b1, TIMEOUT, 1'b0);
    check("t5_dec_vector", {28'd0, dec_vector}, 32'hD);

    // Test 6: reset asserted during RUN of a ch1 window.
    wait_sclr(seen);
    core_pop = 1'b1;
    @(negedge clock);
    check("t6_grant_ch1", {28'd0, ch_pop}, 32'h2);
    reset = 1'b1;
    #1;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_core_empty", {31'd0, core_empty}, 32'd1);
    check("t6_ch_pop", {28'd0, ch_pop}, 32'd0);
    check("t6_dec_vector", {28'd0, dec_vector}, 32'd0);
    check("t6_dec_ch", {30'd0, dec_ch}, 32'd0);
    check("t6_pulses", {29'd0, core_sclr, dec_valid, timeout_err}, 32'd0);
    core_pop = 1'b0;
    exp_vec  = '0;
    @(negedge clock);
    reset = 1'b0;
    run_window(0, 1'b1, 10, 1'b0);
    check("t6_restart_vector", {28'd0, dec_vector}, 32'h1);

    ch_empty = 4'b1111;
    repeat (6) @(negedge clock);
    check("final_idle", {31'd0, busy}, 32'd0);
    check("final_scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
